// File: rtl/psum_accumulator.sv
// Saturating partial-sum accumulator: sums acc_len signed adder outputs and hands the total downstream.
// Define PSUM_ACCUMULATOR_RELU_EN to clamp negative totals to zero at the output register.
module psum_accumulator #(
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int IN_BW   = bw_psum+8,
    parameter int ACC_BW  = 32,
    parameter int CNT_BW  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_BW-1:0]        acc_len,
    input  logic signed [IN_BW-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_BW-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     ovf
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    localparam logic signed [ACC_BW-1:0] MAX_V = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] MIN_V = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic [CNT_BW-1:0]        ONE   = {{(CNT_BW-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic signed [ACC_BW-1:0]  acc_q, acc_d;
    logic [CNT_BW-1:0]         cnt_q, cnt_d;
    logic [CNT_BW-1:0]         len_q, len_d;
    logic signed [ACC_BW-1:0]  out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      ovf_q, ovf_d;

    logic signed [ACC_BW:0]    acc_ext, in_ext, sum_ext;
    logic signed [ACC_BW-1:0]  sat_v;
    logic                      clamp, beat, last_beat;

    function automatic logic is_clamp(input logic signed [ACC_BW:0] v);
        return v[ACC_BW] != v[ACC_BW-1];
    endfunction

    function automatic logic signed [ACC_BW-1:0] sat(input logic signed [ACC_BW:0] v);
        if (is_clamp(v))
            return v[ACC_BW] ? MIN_V : MAX_V;
        return v[ACC_BW-1:0];
    endfunction

    function automatic logic signed [ACC_BW-1:0] out_map(input logic signed [ACC_BW-1:0] v);
`ifdef PSUM_ACCUMULATOR_RELU_EN
        return v[ACC_BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // One guard bit above ACC_BW makes the add exact, so overflow is a sign-bit disagreement.
    assign acc_ext   = {acc_q[ACC_BW-1], acc_q};
    assign in_ext    = {{(ACC_BW+1-IN_BW){in_data[IN_BW-1]}}, in_data};
    assign sum_ext   = acc_ext + in_ext;
    assign sat_v     = sat(sum_ext);
    assign clamp     = is_clamp(sum_ext);
    assign beat      = in_valid && (state_q == S_ACCUM);
    assign last_beat = (cnt_q == len_q - ONE);

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = acc_len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = sat_v;
                    cnt_d = cnt_q + ONE;
                    if (clamp)
                        ovf_d = 1'b1;
                    // len==0 wraps len-1 to all ones, giving a 2^CNT_BW beat run.
                    if (last_beat) begin
                        out_data_d  = out_map(sat_v);
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        len_d   = acc_len;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed + randomized bench for psum_accumulator against a per-beat clamping sum model.
module tb_psum_accumulator;

    localparam int IN_BW  = 28;
    localparam int ACC_BW = 32;
    localparam int CNT_BW = 6;
    localparam longint MAXV = (longint'(1) <<< (ACC_BW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_BW-1));

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     start = 1'b0;
    logic [CNT_BW-1:0]        acc_len = '0;
    logic signed [IN_BW-1:0]  in_data = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [ACC_BW-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic                     busy;
    logic                     ovf;

    int total  = 0;
    int passed = 0;
    longint stim[$];

    psum_accumulator #(.bw(8), .bw_psum(20), .IN_BW(IN_BW), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_len(acc_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        acc_len = CNT_BW'(len);
        tick();
        start   = 1'b0;
    endtask

    // Reference: running sum clamped to the ACC_BW signed range after every beat.
    task automatic model(output longint s, output longint o);
        s = 0;
        o = 0;
        foreach (stim[i]) begin
            s += stim[i];
            if (s > MAXV) begin s = MAXV; o = 1; end
            else if (s < MINV) begin s = MINV; o = 1; end
        end
`ifdef PSUM_ACCUMULATOR_RELU_EN
        if (s < 0) s = 0;
`endif
    endtask

    task automatic feed(input bit gaps);
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = IN_BW'($urandom);
                    tick();
                end
            end
            check("in_ready_accum", 64'(in_ready), 1);
            check("out_valid_early", 64'(out_valid), 0);
            in_valid = 1'b1;
            in_data  = IN_BW'(stim[i]);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic finish_run(input string tag);
        longint es, eo;
        model(es, eo);
        check({tag, "_valid"}, 64'(out_valid), 1);
        check({tag, "_data"}, 64'(out_data), es);
        check({tag, "_ovf"}, 64'(ovf), eo);
        check({tag, "_in_ready"}, 64'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 64'(out_valid), 0);
        check({tag, "_idle"}, 64'(busy), 0);
        check({tag, "_data_hold"}, 64'(out_data), es);
    endtask

    task automatic push_random(input int n, input bit big);
        logic signed [IN_BW-1:0] r;
        stim.delete();
        for (int i = 0; i < n; i++) begin
            r = IN_BW'($urandom);
            if (big) r = {1'b0, r[IN_BW-2:0]} | IN_BW'(32'h0700_0000);
            stim.push_back(longint'(r));
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_busy", 64'(busy), 0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_data", 64'(out_data), 0);

        // Reset mid-ACCUM after three beats discards the run
        do_start(8);
        stim = '{11, 22, 33};
        feed(1'b0);
        #2 reset = 1'b0;
        #1 check("arst_busy_async", 64'(busy), 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("arst_out_valid", 64'(out_valid), 0);
        check("arst_busy", 64'(busy), 0);
        check("arst_in_ready", 64'(in_ready), 0);
        check("arst_out_data", 64'(out_data), 0);
        do_start(2);
        stim = '{5, 7};
        feed(1'b0);
        finish_run("post_reset");

        // Basic run with input gaps
        do_start(4);
        stim = '{100, -30, 7, 1};
        feed(1'b1);
        finish_run("basic");

        // Backpressure, ignored start, then back-to-back run
        do_start(1);
        stim = '{-5};
        out_ready = 1'b0;
        feed(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 64'(out_valid), 1);
            check("bp_data", 64'(out_data), -5);
            check("bp_in_ready", 64'(in_ready), 0);
            start   = (i == 2);
            acc_len = CNT_BW'(3);
            tick();
            start   = 1'b0;
        end
        out_ready = 1'b1;
        do_start(2);
        check("b2b_in_ready", 64'(in_ready), 1);
        check("b2b_valid_drop", 64'(out_valid), 0);
        check("b2b_busy", 64'(busy), 1);
        stim = '{3, 3};
        feed(1'b0);
        finish_run("b2b");

        // Positive saturation; ovf holds until next start
        do_start(20);
        stim.delete();
        repeat (20) stim.push_back((longint'(1) <<< 27) - 1);
        feed(1'b0);
        finish_run("sat_pos");
        check("ovf_sticky", 64'(ovf), 1);
        do_start(2);
        check("ovf_clear", 64'(ovf), 0);
        stim = '{1, 2};
        feed(1'b0);
        finish_run("after_sat");

        // Negative saturation
        do_start(20);
        stim.delete();
        repeat (20) stim.push_back(-(longint'(1) <<< 27));
        feed(1'b1);
        finish_run("sat_neg");

        // Maximum run length (acc_len = 0)
        do_start(0);
        stim.delete();
        repeat (64) stim.push_back(1);
        feed(1'b0);
        finish_run("max_len");

        // Negative total (clamped to zero under the ReLU build)
        do_start(2);
        stim = '{-10, 3};
        feed(1'b0);
        finish_run("relu");

        // Randomized runs, some long enough to saturate
        for (int k = 0; k < 6; k++) begin
            int n;
            n = (k % 2 == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(20, 40));
            push_random(n, k % 2 == 1);
            do_start(n);
            feed(1'b1);
            finish_run("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
